// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit: applies at most STEP bit positions per cycle to an accumulator,
// with valid/ready handshakes on both sides and a synchronous flush.
module shift_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 8,
  parameter int unsigned BITS  = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_operand,
  input  logic [BITS-1:0]  i_amount,
  input  logic             i_dir,
  input  logic             i_mode,
  input  logic             i_arith,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [BITS-1:0] StepAmt = BITS'(STEP);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_acc;
  logic [BITS-1:0]  r_rem;
  logic             r_dir;
  logic             r_mode;
  logic             r_arith;
  logic [BITS-1:0]  w_step;
  logic [BITS-1:0]  w_rem_next;
  logic [WIDTH-1:0] w_shifted;
  logic             w_accept;

  // Single-pass shifter; rotates use a doubled operand so a zero amount needs no special case.
  function automatic logic [WIDTH-1:0] shift_f(input logic [WIDTH-1:0] a,
                                               input logic [BITS-1:0]  s,
                                               input logic             dir,
                                               input logic             mode,
                                               input logic             arith);
    logic [2*WIDTH-1:0] dbl;
    dbl = '0;
    if (!mode) begin
      if (dir) begin
        dbl = {a, a} << s;
        return dbl[2*WIDTH-1:WIDTH];
      end
      dbl = {a, a} >> s;
      return dbl[WIDTH-1:0];
    end
    if (dir) return a << s;
    if (arith) return $unsigned($signed(a) >>> s);
    return a >> s;
  endfunction

  always_comb begin
    w_step     = (r_rem > StepAmt) ? StepAmt : r_rem;
    w_rem_next = r_rem - w_step;
    w_shifted  = shift_f(r_acc, w_step, r_dir, r_mode, r_arith);
    w_accept   = (r_state == StIdle) && i_valid && !i_flush;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = (i_amount == '0) ? StDone : StShift;
      StShift: if (w_rem_next == '0) w_state_next = StDone;
      StDone:  if (i_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (i_flush) w_state_next = StIdle;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_mode  <= 1'b0;
      r_arith <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (i_flush) begin
        r_rem <= '0;
      end else if (w_accept) begin
        r_acc   <= i_operand;
        r_rem   <= i_amount;
        r_dir   <= i_dir;
        r_mode  <= i_mode;
        // Masked so an undriven arith in rotate/left modes cannot reach the datapath.
        r_arith <= i_arith & i_mode & ~i_dir;
      end else if (r_state == StShift) begin
        r_acc <= w_shifted;
        r_rem <= w_rem_next;
      end
    end
  end

  assign o_ready  = (r_state == StIdle) && !i_flush;
  assign o_valid  = (r_state == StDone);
  assign o_busy   = (r_state != StIdle);
  assign o_result = r_acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomised checks of shift_sequencer against a bitwise reference model.
module tb_shift_sequencer;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_operand;
  logic [4:0]  i_amount;
  logic        i_dir;
  logic        i_mode;
  logic        i_arith;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  shift_sequencer #(.WIDTH(32), .STEP(8)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_operand(i_operand),
    .i_amount (i_amount),
    .i_dir    (i_dir),
    .i_mode   (i_mode),
    .i_arith  (i_arith),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit reference, independent of any shift operator.
  function automatic logic [31:0] ref_model(input logic [31:0] op, input int amt,
                                            input logic dir, input logic mode,
                                            input logic arith);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      if (!mode && dir)       r[i] = op[(i - amt + 32) % 32];
      else if (!mode)         r[i] = op[(i + amt) % 32];
      else if (dir)           r[i] = (i >= amt) ? op[i - amt] : 1'b0;
      else if (i + amt < 32)  r[i] = op[i + amt];
      else                    r[i] = arith ? op[31] : 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [31:0] op, input logic [4:0] amt,
                       input logic dir, input logic mode, input logic arith,
                       input logic [31:0] exp, input int bp);
    int t;
    int lat;
    int busy_n;
    logic [31:0] held;
    t = 0;
    while (!o_ready && t < 50) begin
      tick();
      t++;
    end
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    i_operand = op;
    i_amount  = amt;
    i_dir     = dir;
    i_mode    = mode;
    i_arith   = arith;
    i_valid   = 1'b1;
    i_ready   = 1'b0;
    tick();
    i_valid   = 1'b0;
    i_arith   = 1'b0;
    lat       = 0;
    busy_n    = 0;
    while (!o_valid && lat < 20) begin
      if (o_busy) busy_n++;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'((int'(amt) + 7) / 8));
    chk({tag, "_busy"}, 32'(busy_n), 32'(lat));
    chk({tag, "_res"}, o_result, exp);
    held = o_result;
    for (int i = 0; i < bp; i++) begin
      tick();
      chk({tag, "_hold"}, {o_valid, o_result[30:0]}, {1'b1, held[30:0]});
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, "_drain"}, {30'd0, o_valid, o_ready}, 32'b01);
  endtask

  initial begin
    logic [31:0] rop;
    logic [4:0]  ramt;
    logic        rdir;
    logic        rmode;
    logic        rarith;
    int          vseen;

    i_rst = 1'b1; i_valid = 1'b0; i_operand = '0; i_amount = '0; i_dir = 1'b0;
    i_mode = 1'b0; i_arith = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    #12;
    chk("reset_out", {o_valid, o_busy, 30'd0}, 32'd0);
    chk("reset_res", o_result, 32'd0);
    #4 i_rst = 1'b0;
    tick();
    chk("reset_ready", 32'(o_ready), 32'd1);

    // 1-3: directed shifts and rotate
    do_op("sll",  32'h0000AF05, 5'd3,  1'b1, 1'b1, 1'b0, 32'h00057828, 2);
    do_op("sra",  32'h80000000, 5'd20, 1'b0, 1'b1, 1'b1, 32'hFFFFF800, 1);
    do_op("srl",  32'h80000000, 5'd20, 1'b0, 1'b1, 1'b0, 32'h00000800, 0);
    do_op("ror",  32'h12345678, 5'd31, 1'b0, 1'b0, 1'bx, 32'h2468ACF0, 0);
    do_op("rol",  32'h12345678, 5'd4,  1'b1, 1'b0, 1'b0, 32'h23456781, 0);
    do_op("sra8", 32'h40000000, 5'd8,  1'b0, 1'b1, 1'b1, 32'h00400000, 0);

    // 4: zero amount, backpressure with a competing request
    i_operand = 32'hDEADBEEF; i_amount = 5'd0; i_dir = 1'b0; i_mode = 1'b1; i_valid = 1'b1;
    tick();
    chk("z_valid", 32'(o_valid), 32'd1);
    chk("z_res", o_result, 32'hDEADBEEF);
    i_operand = 32'h11111111; i_amount = 5'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("z_hold", {o_valid, o_ready, 30'd0}, {2'b10, 30'd0});
      chk("z_hold_res", o_result, 32'hDEADBEEF);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("z_idle", {o_valid, o_busy, o_ready, 29'd0}, {3'b001, 29'd0});
    chk("z_not_taken", o_result, 32'hDEADBEEF);

    // 5a: flush on the second SHIFT cycle
    i_operand = 32'hFFFFFFFF; i_amount = 5'd31; i_dir = 1'b0; i_mode = 1'b1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    i_flush = 1'b1;
    chk("fl_ready_gated", 32'(o_ready), 32'd0);
    tick();
    i_flush = 1'b0;
    chk("fl_busy", {o_busy, o_valid, 30'd0}, 32'd0);
    vseen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_valid) vseen++;
    end
    chk("fl_no_valid", 32'(vseen), 32'd0);
    do_op("fl_next", 32'h00000001, 5'd9, 1'b1, 1'b1, 1'b0, 32'h00000200, 0);

    // 5b: asynchronous reset between edges
    i_operand = 32'hFFFFFFFF; i_amount = 5'd31; i_dir = 1'b0; i_mode = 1'b1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    chk("rs_busy_before", 32'(o_busy), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("rs_out", {o_valid, o_busy, 30'd0}, 32'd0);
    chk("rs_res", o_result, 32'd0);
    #1 i_rst = 1'b0;
    vseen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_valid || o_busy) vseen++;
    end
    chk("rs_no_valid", 32'(vseen), 32'd0);
    do_op("rs_next", 32'h00000001, 5'd9, 1'b1, 1'b1, 1'b0, 32'h00000200, 0);

    // 6: randomised ops against the reference model
    for (int n = 0; n < 1024; n++) begin
      rop    = $urandom;
      ramt   = 5'($urandom_range(0, 31));
      rdir   = 1'($urandom_range(0, 1));
      rmode  = 1'($urandom_range(0, 1));
      rarith = 1'($urandom_range(0, 1));
      do_op("rnd", rop, ramt, rdir, rmode, rarith,
            ref_model(rop, int'(ramt), rdir, rmode, rarith & rmode & ~rdir),
            int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
